// File: rtl/sync_pack_prefetch_fifo_if.sv
// Bus bundle for the lane-packing prefetch FIFO: narrow write lanes in, wide packed words out.
interface sync_pack_prefetch_fifo_if #(
  parameter int WR_DATA_WIDTH = 16,
  parameter int PACK_RATIO    = 8,
  parameter int DEPTH_WIDTH   = 9
);
  // Handshake: wr_en/wr_flush act only in a cycle where wr_vld=1; rd_en pops only in a
  // cycle where rd_vld=1. Requests outside those cycles are ignored and raise the sticky flags.
  logic                                  wr_en;
  logic [WR_DATA_WIDTH-1:0]              wr_data;
  logic                                  wr_flush;
  logic                                  wr_vld;
  logic                                  rd_en;
  logic                                  rd_vld;
  logic [WR_DATA_WIDTH*PACK_RATIO-1:0]   rd_data;
  logic [$clog2(PACK_RATIO):0]           rd_fill;
  logic [DEPTH_WIDTH+1:0]                level;
  logic                                  almost_full;
  logic                                  overflow;
  logic                                  underflow;

  modport master (
    output wr_en, wr_data, wr_flush, rd_en,
    input  wr_vld, rd_vld, rd_data, rd_fill, level, almost_full, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, wr_flush, rd_en,
    output wr_vld, rd_vld, rd_data, rd_fill, level, almost_full, overflow, underflow
  );
endinterface

// File: rtl/sync_pack_prefetch_fifo.sv
// First-word-fall-through FIFO that packs PACK_RATIO narrow lanes per stored word,
// with partial-word flush, fill level, almost-full and sticky error flags.
module sync_pack_prefetch_fifo #(
  parameter int WR_DATA_WIDTH  = 16,
  parameter int PACK_RATIO     = 8,
  parameter int DEPTH_WIDTH    = 9,
  parameter int ALMOST_FULL_TH = 480,
  parameter int LSB_FIRST      = 1
) (
  input logic clk,
  input logic rst,
  sync_pack_prefetch_fifo_if.slave bus
);
  localparam int RW    = WR_DATA_WIDTH * PACK_RATIO;
  localparam int CW    = $clog2(PACK_RATIO) + 1;
  localparam int PW    = DEPTH_WIDTH + 1;
  localparam int LW    = DEPTH_WIDTH + 2;
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [RW-1:0] mem_data [DEPTH];
  logic [CW-1:0] mem_fill [DEPTH];

  logic [CW-1:0] lane_cnt;
  logic [RW-1:0] shadow;
  logic [PW-1:0] wr_ptr, wr_ptr_vis, rd_ptr;
  logic          rd_vld_q, wr_vld_q, almost_full_q, overflow_q, underflow_q;
  logic [RW-1:0] rd_data_q;
  logic [CW-1:0] rd_fill_q;
  logic [LW-1:0] level_q;

  logic          acc_wr, acc_fl, last_lane, push, pop, load, arr_empty_vis;
  logic          rd_vld_nxt, full_nxt;
  logic [CW-1:0] lane_pos, push_fill;
  logic [RW-1:0] word_ins, push_data;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic [LW-1:0] level_nxt;

  assign acc_wr    = bus.wr_en & wr_vld_q;
  assign acc_fl    = bus.wr_flush & wr_vld_q;
  assign last_lane = (lane_cnt == CW'(PACK_RATIO - 1));
  assign lane_pos  = (LSB_FIRST != 0) ? lane_cnt : (CW'(PACK_RATIO - 1) - lane_cnt);

  always_comb begin
    word_ins = shadow;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (lane_pos == CW'(k)) word_ins[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] = bus.wr_data;
    end
  end

  // A flush on an empty packer is a no-op unless it carries a lane of its own.
  assign push      = (acc_wr && last_lane) || (acc_fl && (acc_wr || (lane_cnt != '0)));
  assign push_data = acc_wr ? word_ins : shadow;
  assign push_fill = lane_cnt + CW'(acc_wr);

  // The array is seen by the prefetch stage through a one-edge delayed write pointer,
  // which gives the two-edge write-to-read latency while still allowing back-to-back pops.
  assign arr_empty_vis = (rd_ptr == wr_ptr_vis);
  assign pop           = bus.rd_en & rd_vld_q;
  assign load          = !arr_empty_vis && (!rd_vld_q || pop);
  assign rd_vld_nxt    = load | (rd_vld_q & ~pop);

  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(load);
  assign cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  assign full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                      (wr_ptr_nxt[PW-2:0] == rd_ptr_nxt[PW-2:0]);
  assign level_nxt  = LW'(cnt_nxt) + LW'(rd_vld_nxt);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[PW-2:0]] <= push_data;
      mem_fill[wr_ptr[PW-2:0]] <= push_fill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt      <= '0;
      shadow        <= '0;
      wr_ptr        <= '0;
      wr_ptr_vis    <= '0;
      rd_ptr        <= '0;
      rd_vld_q      <= 1'b0;
      rd_data_q     <= '0;
      rd_fill_q     <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      wr_vld_q      <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | ((bus.wr_en | bus.wr_flush) & ~wr_vld_q);
      underflow_q <= underflow_q | (bus.rd_en & ~rd_vld_q);
      if (push) begin
        lane_cnt <= '0;
        shadow   <= '0;
      end else if (acc_wr) begin
        lane_cnt <= lane_cnt + CW'(1);
        shadow   <= word_ins;
      end
      wr_ptr     <= wr_ptr_nxt;
      wr_ptr_vis <= wr_ptr;
      rd_ptr     <= rd_ptr_nxt;
      rd_vld_q   <= rd_vld_nxt;
      if (load) begin
        rd_data_q <= mem_data[rd_ptr[PW-2:0]];
        rd_fill_q <= mem_fill[rd_ptr[PW-2:0]];
      end
      level_q       <= level_nxt;
      almost_full_q <= (level_nxt >= LW'(ALMOST_FULL_TH));
      wr_vld_q      <= !full_nxt;
    end
  end

  assign bus.wr_vld      = wr_vld_q;
  assign bus.rd_vld      = rd_vld_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_fill     = rd_fill_q;
  assign bus.level       = level_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_sync_pack_prefetch_fifo.sv
// Directed bench: vector table for packing/flush timing, plus fill/drain, reset and streaming sequences.
module tb_sync_pack_prefetch_fifo;
  localparam int W  = 16;
  localparam int PR = 8;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sync_pack_prefetch_fifo_if #(.WR_DATA_WIDTH(W), .PACK_RATIO(PR), .DEPTH_WIDTH(DW)) bus ();

  sync_pack_prefetch_fifo #(
    .WR_DATA_WIDTH(W), .PACK_RATIO(PR), .DEPTH_WIDTH(DW), .ALMOST_FULL_TH(12), .LSB_FIRST(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr_en;
    logic [15:0]  wr_data;
    logic         wr_flush;
    logic         rd_en;
    logic         exp_rd_vld;
    logic [127:0] exp_data;
    logic [3:0]   exp_fill;
    logic         chk_lvl;
    logic [5:0]   exp_level;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [15:0] wd, input logic wf, input logic re,
                         input logic ev, input logic [127:0] ed, input logic [3:0] ef,
                         input logic cl, input logic [5:0] el);
    vec_t v;
    v.wr_en = we; v.wr_data = wd; v.wr_flush = wf; v.rd_en = re;
    v.exp_rd_vld = ev; v.exp_data = ed; v.exp_fill = ef; v.chk_lvl = cl; v.exp_level = el;
    vecs.push_back(v);
  endtask

  function automatic logic [15:0] lane_val(input int w, input int l);
    return 16'(w * 256 + l);
  endfunction

  function automatic logic [127:0] mk_word(input int w);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < PR; l++) r[l*W +: W] = lane_val(w, l);
    return r;
  endfunction

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_flush = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic write_word_lanes(input int w, input int n, input logic re);
    for (int l = 0; l < n; l++) begin
      bus.wr_en = 1'b1; bus.wr_data = lane_val(w, l); bus.rd_en = re;
      tick();
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_rd_vld"}, bus.rd_vld, 1'b0);
    chk({tag, "_rd_data"}, bus.rd_data, '0);
    chk({tag, "_rd_fill"}, 128'(bus.rd_fill), '0);
    chk({tag, "_level"}, 128'(bus.level), '0);
    chk1({tag, "_almost_full"}, bus.almost_full, 1'b0);
    chk1({tag, "_overflow"}, bus.overflow, 1'b0);
    chk1({tag, "_underflow"}, bus.underflow, 1'b0);
    chk1({tag, "_wr_vld"}, bus.wr_vld, 1'b0);
  endtask

  initial begin
    // Packing, flush and latency vectors; level is skipped on push edges.
    for (int k = 0; k < 7; k++) add_vec(1, 16'(k + 1), 0, 0, 0, '0, 0, 1, 0);
    add_vec(1, 16'h0008, 0, 0, 0, '0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, '0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 1, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 8, 1, 1);
    add_vec(1, 16'hAAAA, 0, 1, 0, '0, 0, 1, 0);
    add_vec(1, 16'hBBBB, 0, 0, 0, '0, 0, 1, 0);
    add_vec(0, 0, 1, 0, 0, '0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, '0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 1, 128'h0000_0000_0000_0000_0000_0000_BBBB_AAAA, 2, 1, 1);
    add_vec(0, 0, 0, 0, 1, 128'h0000_0000_0000_0000_0000_0000_BBBB_AAAA, 2, 1, 1);
    add_vec(1, 16'hCCCC, 0, 1, 0, '0, 0, 1, 0);
    add_vec(1, 16'hDDDD, 1, 0, 0, '0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, '0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 1, 128'h0000_0000_0000_0000_0000_0000_DDDD_CCCC, 2, 1, 1);
    add_vec(0, 0, 1, 1, 0, '0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, '0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, '0, 0, 1, 0);
    for (int k = 0; k < 7; k++) add_vec(1, 16'(16'h0010 + k), 0, 0, 0, '0, 0, 1, 0);
    add_vec(1, 16'h0017, 1, 0, 0, '0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, '0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 1, 128'h0017_0016_0015_0014_0013_0012_0011_0010, 8, 1, 1);
    add_vec(0, 0, 0, 0, 1, 128'h0017_0016_0015_0014_0013_0012_0011_0010, 8, 1, 1);
    add_vec(0, 0, 0, 1, 0, '0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, '0, 0, 1, 0);

    // Clock/reset
    rst = 1'b1;
    idle_inputs();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    chk1("wr_vld_after_reset", bus.wr_vld, 1'b1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      bus.wr_en = vecs[i].wr_en; bus.wr_data = vecs[i].wr_data;
      bus.wr_flush = vecs[i].wr_flush; bus.rd_en = vecs[i].rd_en;
      tick();
      chk1($sformatf("v%0d_rd_vld", i), bus.rd_vld, vecs[i].exp_rd_vld);
      if (vecs[i].exp_rd_vld) begin
        chk($sformatf("v%0d_rd_data", i), bus.rd_data, vecs[i].exp_data);
        chk($sformatf("v%0d_rd_fill", i), 128'(bus.rd_fill), 128'(vecs[i].exp_fill));
      end
      if (vecs[i].chk_lvl) chk($sformatf("v%0d_level", i), 128'(bus.level), 128'(vecs[i].exp_level));
    end
    idle_inputs();
    chk1("no_overflow_yet", bus.overflow, 1'b0);

    // Fill 17 words (16 in array + prefetch) with no reads
    exp_q.delete();
    for (int w = 0; w < 17; w++) begin
      for (int l = 0; l < PR; l++) begin
        bus.wr_en = 1'b1; bus.wr_data = lane_val(w, l);
        if (w == 16 && l == 7) chk1("wr_vld_before_full", bus.wr_vld, 1'b1);
        tick();
        if (l == 3) begin
          chk($sformatf("fill_w%0d_level", w), 128'(bus.level), 128'(w));
          chk1($sformatf("fill_w%0d_af", w), bus.almost_full, (w >= 12));
          chk1($sformatf("fill_w%0d_wr_vld", w), bus.wr_vld, 1'b1);
        end
      end
      exp_q.push_back(mk_word(w));
    end
    chk1("wr_vld_full", bus.wr_vld, 1'b0);
    idle_inputs();
    tick(); tick();
    chk("full_level", 128'(bus.level), 128'(17));
    chk1("full_af", bus.almost_full, 1'b1);
    bus.wr_en = 1'b1; bus.wr_data = 16'hDEAD;
    tick();
    idle_inputs();
    chk1("overflow_set", bus.overflow, 1'b1);
    chk("overflow_level", 128'(bus.level), 128'(17));
    chk1("overflow_wr_vld", bus.wr_vld, 1'b0);

    // Drain at one word per cycle, then an ignored read
    for (int i = 0; i < 18; i++) begin
      bus.rd_en = 1'b1;
      chk1($sformatf("drain%0d_rd_vld", i), bus.rd_vld, (i < 17));
      if (bus.rd_vld) begin
        if (exp_q.size() == 0) chk1("drain_exp_q_empty", 1'b1, 1'b0);
        else chk($sformatf("drain%0d_data", i), bus.rd_data, exp_q.pop_front());
        chk($sformatf("drain%0d_fill", i), 128'(bus.rd_fill), 128'(8));
      end
      if (i == 17) chk1("underflow_clear_before", bus.underflow, 1'b0);
      tick();
    end
    idle_inputs();
    chk1("underflow_set", bus.underflow, 1'b1);
    chk("drained_level", 128'(bus.level), '0);
    chk1("drained_af", bus.almost_full, 1'b0);

    // Reset with level 5 and three lanes pending
    for (int w = 20; w < 25; w++) write_word_lanes(w, PR, 1'b0);
    write_word_lanes(25, 3, 1'b0);
    tick(); tick(); tick();
    chk("pre_reset_level", 128'(bus.level), 128'(5));
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    rst = 1'b0;
    tick();
    chk1("post_reset_wr_vld", bus.wr_vld, 1'b1);
    write_word_lanes(30, PR, 1'b0);
    tick();
    chk1("post_reset_not_yet", bus.rd_vld, 1'b0);
    tick();
    chk1("post_reset_rd_vld", bus.rd_vld, 1'b1);
    chk("post_reset_data", bus.rd_data, mk_word(30));
    chk("post_reset_fill", 128'(bus.rd_fill), 128'(8));
    chk("post_reset_level", 128'(bus.level), 128'(1));
    bus.rd_en = 1'b1;
    tick();
    idle_inputs();

    // Streaming at one lane per cycle with reads always enabled, wrapping the pointers
    exp_q.delete();
    for (int w = 40; w < 60; w++) begin
      for (int l = 0; l < PR; l++) begin
        bus.wr_en = 1'b1; bus.wr_data = lane_val(w, l); bus.rd_en = 1'b1;
        if (bus.rd_vld) begin
          if (exp_q.size() == 0) chk1("stream_exp_q_empty", 1'b1, 1'b0);
          else chk($sformatf("stream_w%0d_l%0d_data", w, l), bus.rd_data, exp_q.pop_front());
        end
        tick();
        chk1($sformatf("stream_w%0d_l%0d_lvl_le1", w, l), (bus.level <= 6'd1), 1'b1);
      end
      exp_q.push_back(mk_word(w));
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rd_vld) begin
        if (exp_q.size() == 0) chk1("tail_exp_q_empty", 1'b1, 1'b0);
        else chk($sformatf("tail%0d_data", i), bus.rd_data, exp_q.pop_front());
      end
      tick();
    end
    idle_inputs();
    chk("stream_all_delivered", 128'(exp_q.size()), '0);
    chk1("stream_no_overflow", bus.overflow, 1'b0);
    chk("stream_level", 128'(bus.level), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
